// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  // Data grants allowed in a row while a fetch is waiting.
  localparam int D_BURST_MAX_DEF = 4;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LH  = 4'd1,
    LW  = 4'd2,
    LBU = 4'd3,
    LHU = 4'd4,
    SB  = 4'd5,
    SH  = 4'd6,
    SW  = 4'd7
  } mem_ctrl_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4,
    ERR_D  = 3'd5
  } arb_state_e;

  function automatic logic is_store(input logic [3:0] ctrl);
    return (ctrl == SB) || (ctrl == SH) || (ctrl == SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, alignment
// check, and load byte/half selection with sign or zero extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [3:0]  i_ctrl,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // Decode access type into lanes, alignment status and extended load value.
  always_comb begin
    o_be       = 4'hF;
    o_wdata    = i_wdata;
    o_misalign = 1'b0;
    o_rdata    = 32'd0;
    case (i_ctrl)
      LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
      LH: begin
        o_misalign = i_addr_lo[0];
        o_rdata    = {{16{w_half[15]}}, w_half};
      end
      LW: begin
        o_misalign = |i_addr_lo;
        o_rdata    = i_rword;
      end
      LBU: o_rdata = {24'd0, w_byte};
      LHU: begin
        o_misalign = i_addr_lo[0];
        o_rdata    = {16'd0, w_half};
      end
      SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SH: begin
        o_misalign = i_addr_lo[0];
        o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
      end
      SW:      o_misalign = |i_addr_lo;
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// load/store. Each access runs grant -> memory wait -> one-cycle response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int D_BURST_MAX = D_BURST_MAX_DEF,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_mem_ctrl,
  output logic [31:0]   d_rdata,
  output logic          d_valid,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [3:0]    m_be,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  input  logic          m_ready
);

  localparam int CW = $clog2(D_BURST_MAX + 1);

  arb_state_e    r_state, w_next;
  logic [CW-1:0] r_burst;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata, r_rword;
  logic [3:0]    r_be, r_ctrl;
  logic          r_we;

  logic          w_fetch_first, w_grant_d, w_grant_i, w_busy, w_misalign;
  logic [3:0]    w_ctrl, w_be;
  logic [1:0]    w_addr_lo;
  logic [31:0]   w_wdata, w_ext;

  // Fetch overrides data only once the data burst limit is reached.
  assign w_fetch_first = if_req && (r_burst == CW'(D_BURST_MAX));
  assign w_grant_d     = (r_state == IDLE) && d_req && !w_fetch_first;
  assign w_grant_i     = (r_state == IDLE) && if_req && !w_grant_d;
  assign w_busy        = (r_state == BUSY_I) || (r_state == BUSY_D);

  // Lane logic sees the live request at grant time, the held one afterwards.
  assign w_ctrl    = (r_state == IDLE) ? d_mem_ctrl  : r_ctrl;
  assign w_addr_lo = (r_state == IDLE) ? d_addr[1:0] : r_addr[1:0];

  mem_lane_align u_align (
    .i_ctrl     (w_ctrl),
    .i_addr_lo  (w_addr_lo),
    .i_wdata    (d_wdata),
    .i_rword    (r_rword),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign),
    .o_rdata    (w_ext)
  );

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: grant from IDLE, wait for m_ready in BUSY, single response cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next = w_misalign ? ERR_D : BUSY_D;
        else if (w_grant_i) w_next = BUSY_I;
      end
      BUSY_I:  if (m_ready) w_next = RESP_I;
      BUSY_D:  if (m_ready) w_next = RESP_D;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; response data comes from the captured word.
  always_comb begin
    m_req    = w_busy;
    if_valid = (r_state == RESP_I);
    d_valid  = (r_state == RESP_D) || (r_state == ERR_D);
    d_err    = (r_state == ERR_D);
    if_rdata = (r_state == RESP_I) ? r_rword : 32'd0;
    d_rdata  = (r_state == RESP_D) ? w_ext   : 32'd0;
  end

  assign m_addr  = {r_addr[AW-1:2], 2'b00};
  assign m_be    = r_be;
  assign m_we    = r_we;
  assign m_wdata = r_wdata;

  // Burst counter: counts data grants while a fetch waits, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_burst <= '0;
    else if (w_grant_i)         r_burst <= '0;
    else if (w_grant_d) begin
      if (!if_req)              r_burst <= '0;
      else if (r_burst != CW'(D_BURST_MAX)) r_burst <= r_burst + CW'(1);
    end
  end

  // Access registers latched at grant and held; read word latched on m_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_ctrl  <= '0;
      r_rword <= '0;
    end else begin
      if (w_grant_d) begin
        r_addr  <= d_addr;
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_we    <= is_store(d_mem_ctrl);
        r_ctrl  <= d_mem_ctrl;
      end else if (w_grant_i) begin
        r_addr  <= if_addr;
        r_wdata <= 32'd0;
        r_be    <= 4'hF;
        r_we    <= 1'b0;
        r_ctrl  <= LW;
      end
      if (w_busy && m_ready) r_rword <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked on
// every cycle, plus directed scenarios with literal expected values.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_mem_ctrl = '0;
  logic [31:0] d_rdata;
  logic        d_valid, d_err;
  logic        m_req, m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.D_BURST_MAX(MAXB), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_mem_ctrl(d_mem_ctrl),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int nbytes(input logic [3:0] c);
    if (c == 4'd0 || c == 4'd3 || c == 4'd5) return 1;
    if (c == 4'd1 || c == 4'd4 || c == 4'd6) return 2;
    return 4;
  endfunction

  function automatic bit is_st(input logic [3:0] c);
    return (c >= 4'd5) && (c <= 4'd7);
  endfunction

  function automatic bit bad_acc(input logic [3:0] c, input logic [31:0] a);
    return (c >= 4'd8) || ((int'(a[1:0]) % nbytes(c)) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] c, input logic [31:0] a);
    int v;
    if (!is_st(c)) return 4'hF;
    v = ((1 << nbytes(c)) - 1) << int'(a[1:0]);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [3:0] c, input logic [31:0] w);
    if (nbytes(c) == 1) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (nbytes(c) == 2) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] word);
    longint v;
    int     bits;
    if (is_st(c)) return 32'd0;
    bits = 8 * nbytes(c);
    v = (longint'(word) >> (8 * int'(a[1:0]))) & ((64'd1 << bits) - 1);
    if ((c == 4'd0 || c == 4'd1) && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // Model state: ph 0 waiting for grant, 1 memory access, 2 reply; kind 0 fetch, 1 data, 2 error.
  int          ph = 0, kind = 0, streak = 0;
  logic [31:0] t_addr = '0, t_wd = '0, t_word = '0;
  logic [3:0]  t_ctrl = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= 0;
      streak <= 0;
    end else begin
      case (ph)
        0: begin
          if (d_req && !(if_req && streak == MAXB)) begin
            t_ctrl <= d_mem_ctrl;
            t_addr <= d_addr;
            t_wd   <= d_wdata;
            streak <= if_req ? ((streak < MAXB) ? streak + 1 : MAXB) : 0;
            kind   <= bad_acc(d_mem_ctrl, d_addr) ? 2 : 1;
            ph     <= bad_acc(d_mem_ctrl, d_addr) ? 2 : 1;
          end else if (if_req) begin
            t_addr <= if_addr;
            streak <= 0;
            kind   <= 0;
            ph     <= 1;
          end
        end
        1: if (m_ready) begin
          t_word <= m_rdata;
          ph     <= 2;
        end
        default: ph <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m_req", {31'd0, m_req}, 32'd0);
      chk("rst_m_we", {31'd0, m_we}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_m_be", {28'd0, m_be}, 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_valids", {29'd0, if_valid, d_valid, d_err}, 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    end else begin
      chk("m_req", {31'd0, m_req}, {31'd0, ph == 1});
      if (ph == 1) begin
        chk("m_addr", m_addr, t_addr & ~32'd3);
        if (kind == 1) begin
          chk("m_we", {31'd0, m_we}, {31'd0, is_st(t_ctrl)});
          chk("m_be", {28'd0, m_be}, {28'd0, exp_be(t_ctrl, t_addr)});
          if (is_st(t_ctrl)) chk("m_wdata", m_wdata, exp_wd(t_ctrl, t_wd));
        end else begin
          chk("m_we_fetch", {31'd0, m_we}, 32'd0);
          chk("m_be_fetch", {28'd0, m_be}, 32'hF);
        end
      end
      chk("if_valid", {31'd0, if_valid}, {31'd0, ph == 2 && kind == 0});
      chk("d_valid", {31'd0, d_valid}, {31'd0, ph == 2 && kind != 0});
      chk("d_err", {31'd0, d_err}, {31'd0, ph == 2 && kind == 2});
      if (ph == 2 && kind == 0) chk("if_rdata", if_rdata, t_word);
      if (ph == 2 && kind == 1) chk("d_rdata", d_rdata, exp_ld(t_ctrl, t_addr, t_word));
      if (ph == 2 && kind == 2) chk("d_rdata_err", d_rdata, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic data_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input int waits,
                          output int lat, output int mreq_cyc, output int we_cyc,
                          output int vcnt, output logic [3:0] be, output logic [31:0] mwd,
                          output logic [31:0] rd, output logic err);
    lat = -1; mreq_cyc = 0; we_cyc = 0; vcnt = 0; be = '0; mwd = '0; rd = '0; err = 1'b0;
    d_req = 1'b1; d_mem_ctrl = c; d_addr = a; d_wdata = wd; m_rdata = rw; m_ready = 1'b0;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      nxt();
      if (m_req) begin
        mreq_cyc++;
        be  = m_be;
        mwd = m_wdata;
        if (m_we) we_cyc++;
        m_ready = (mreq_cyc > waits);
      end
      if (d_valid) begin
        vcnt++;
        lat = k;
        rd  = d_rdata;
        err = d_err;
      end
    end
    nxt();
    if (d_valid) vcnt++;
    d_req = 1'b0;
    m_ready = 1'b0;
    nxt();
    if (d_valid) vcnt++;
  endtask

  int          lat, mc, wc, vc;
  logic [3:0]  be;
  logic [31:0] mwd, rd;
  logic        er;
  string       got, exp_s;

  initial begin
    repeat (2) nxt();
    chk("reset_m_req", {31'd0, m_req}, 32'd0);
    chk("reset_d_valid", {31'd0, d_valid}, 32'd0);
    rst = 1'b0;
    nxt();

    // Fetch, zero wait states.
    if_req = 1'b1; if_addr = 32'h100; m_ready = 1'b1; m_rdata = 32'h0050_0093;
    nxt();
    chk("fetch_c1_m_req", {31'd0, m_req}, 32'd1);
    chk("fetch_c1_m_addr", m_addr, 32'h100);
    nxt();
    chk("fetch_c2_if_valid", {31'd0, if_valid}, 32'd1);
    chk("fetch_c2_if_rdata", if_rdata, 32'h0050_0093);
    nxt();
    if_req = 1'b0; m_ready = 1'b0;
    chk("fetch_c3_if_valid", {31'd0, if_valid}, 32'd0);
    nxt();

    // lb / lbu from top byte lane.
    data_txn(4'd0, 32'h203, 32'd0, 32'h80FF_FF7F, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("lb_latency", lat, 32'd2);
    chk("lb_be", {28'd0, be}, 32'hF);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    data_txn(4'd3, 32'h203, 32'd0, 32'h80FF_FF7F, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("lbu_rdata", rd, 32'h0000_0080);

    // sh to upper half with three wait states.
    data_txn(4'd6, 32'h302, 32'h1234_ABCD, 32'hDEAD_BEEF, 3, lat, mc, wc, vc, be, mwd, rd, er);
    chk("sh_be", {28'd0, be}, 32'hC);
    chk("sh_wdata", mwd, 32'hABCD_ABCD);
    chk("sh_we_cycles", wc, 32'd4);
    chk("sh_valid_pulses", vc, 32'd1);
    chk("sh_rdata", rd, 32'd0);

    // Misaligned word and illegal control.
    data_txn(4'd2, 32'h401, 32'd0, 32'd0, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("lw_mis_latency", lat, 32'd1);
    chk("lw_mis_m_req", mc, 32'd0);
    chk("lw_mis_err", {31'd0, er}, 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    data_txn(4'd9, 32'h400, 32'd0, 32'd0, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("ctrl9_err", {31'd0, er}, 32'd1);
    chk("ctrl9_m_req", mc, 32'd0);

    // Further lane patterns, checked by the model every cycle.
    data_txn(4'd5, 32'h11, 32'h0000_00A5, 32'd0, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("sb_be", {28'd0, be}, 32'h2);
    chk("sb_wdata", mwd, 32'hA5A5_A5A5);
    data_txn(4'd1, 32'h2, 32'd0, 32'h8001_7FFF, 1, lat, mc, wc, vc, be, mwd, rd, er);
    chk("lh_hi_rdata", rd, 32'hFFFF_8001);
    data_txn(4'd1, 32'h0, 32'd0, 32'h8001_7FFF, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("lh_lo_rdata", rd, 32'h0000_7FFF);
    data_txn(4'd4, 32'h6, 32'd0, 32'h8001_7FFF, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("lhu_rdata", rd, 32'h0000_8001);
    data_txn(4'd7, 32'h40, 32'hCAFE_F00D, 32'd0, 2, lat, mc, wc, vc, be, mwd, rd, er);
    chk("sw_be", {28'd0, be}, 32'hF);
    chk("sw_wdata", mwd, 32'hCAFE_F00D);
    data_txn(4'd2, 32'h40, 32'd0, 32'h1357_9BDF, 0, lat, mc, wc, vc, be, mwd, rd, er);
    chk("lw_rdata", rd, 32'h1357_9BDF);

    // Both requesters held through reset release: arbitration order.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_mem_ctrl = 4'd2; d_addr = 32'h2000;
    m_rdata = 32'h0BAD_F00D; m_ready = 1'b1;
    nxt();
    rst = 1'b0;
    got = "";
    for (int k = 0; k < 60 && got.len() < 10; k++) begin
      nxt();
      if (d_valid)  got = {got, "D"};
      if (if_valid) got = {got, "I"};
    end
    exp_s = "DDDDIDDDDI";
    chk("order_len", got.len(), 32'd10);
    for (int i = 0; i < 10 && i < got.len(); i++)
      chk($sformatf("order_%0d", i), {24'd0, got[i]}, {24'd0, exp_s[i]});
    if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    repeat (3) nxt();

    // Reset in the middle of a data access.
    d_req = 1'b1; d_mem_ctrl = 4'd2; d_addr = 32'h500; m_ready = 1'b0;
    nxt();
    nxt();
    chk("abort_busy_m_req", {31'd0, m_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_m_req_async", {31'd0, m_req}, 32'd0);
    nxt();
    d_req = 1'b0;
    nxt();
    rst = 1'b0;
    vc = 0; mc = 0;
    for (int k = 0; k < 4; k++) begin
      nxt();
      if (d_valid) vc++;
      if (m_req) mc++;
    end
    chk("abort_no_d_valid", vc, 32'd0);
    chk("abort_idle_m_req", mc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
